// File: rtl/line_drawer_arbiter.sv
// Round-robin arbiter that buffers one line per requester and feeds a single
// shared line_drawer through its start/ready handshake.
module line_drawer_arbiter #(
  parameter  int HOR_ACTIVE_PIXELS = 640,
  parameter  int VER_ACTIVE_PIXELS = 480,
  parameter  int REQUESTERS        = 3,
  localparam int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
  localparam int GRANT_WIDTH       = $clog2(REQUESTERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQUESTERS-1:0]         req_start,
  output logic [REQUESTERS-1:0]         req_ready,
  input  logic [REQUESTERS*X_WIDTH-1:0] req_x1,
  input  logic [REQUESTERS*Y_WIDTH-1:0] req_y1,
  input  logic [REQUESTERS*X_WIDTH-1:0] req_x2,
  input  logic [REQUESTERS*Y_WIDTH-1:0] req_y2,
  output logic [X_WIDTH-1:0]            x1,
  output logic [Y_WIDTH-1:0]            y1,
  output logic [X_WIDTH-1:0]            x2,
  output logic [Y_WIDTH-1:0]            y2,
  output logic                          line_drawer_start,
  input  logic                          line_drawer_ready,
  output logic                          busy,
  output logic [GRANT_WIDTH-1:0]        grant
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [REQUESTERS-1:0]    r_pending;
  logic [REQUESTERS-1:0]    r_req_ready;
  logic [GRANT_WIDTH-1:0]   r_grant;
  logic [GRANT_WIDTH-1:0]   r_rr_ptr;
  logic                     r_start;
  logic [X_WIDTH-1:0]       r_x1;
  logic [Y_WIDTH-1:0]       r_y1;
  logic [X_WIDTH-1:0]       r_x2;
  logic [Y_WIDTH-1:0]       r_y2;

  logic [X_WIDTH-1:0]       r_slot_x1 [REQUESTERS];
  logic [Y_WIDTH-1:0]       r_slot_y1 [REQUESTERS];
  logic [X_WIDTH-1:0]       r_slot_x2 [REQUESTERS];
  logic [Y_WIDTH-1:0]       r_slot_y2 [REQUESTERS];

  logic [REQUESTERS-1:0]    w_accept;
  logic                     w_found;
  logic [GRANT_WIDTH-1:0]   w_winner;
  logic [GRANT_WIDTH:0]     w_sum;
  logic [GRANT_WIDTH-1:0]   w_next_ptr;

  function automatic logic [X_WIDTH-1:0] clamp_x(input logic [X_WIDTH-1:0] v);
    return (int'(v) >= HOR_ACTIVE_PIXELS) ? X_WIDTH'(HOR_ACTIVE_PIXELS - 1) : v;
  endfunction

  function automatic logic [Y_WIDTH-1:0] clamp_y(input logic [Y_WIDTH-1:0] v);
    return (int'(v) >= VER_ACTIVE_PIXELS) ? Y_WIDTH'(VER_ACTIVE_PIXELS - 1) : v;
  endfunction

  assign w_accept   = req_start & r_req_ready;
  assign w_next_ptr = (r_grant == GRANT_WIDTH'(REQUESTERS - 1)) ? '0 : r_grant + 1'b1;

  // NOTE: every variable gets a default before the loop, so no path can infer a latch.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (GRANT_WIDTH + 1)'(k);
      if (w_sum >= (GRANT_WIDTH + 1)'(REQUESTERS)) begin
        w_sum = w_sum - (GRANT_WIDTH + 1)'(REQUESTERS);
      end
      if (!w_found && r_pending[w_sum[GRANT_WIDTH-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[GRANT_WIDTH-1:0];
      end
    end
  end

  // NOTE: slot storage is deliberately not reset; a slot is only read while its
  // pending bit is set, and pending is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_accept[i]) begin
        r_slot_x1[i] <= clamp_x(req_x1[i*X_WIDTH +: X_WIDTH]);
        r_slot_y1[i] <= clamp_y(req_y1[i*Y_WIDTH +: Y_WIDTH]);
        r_slot_x2[i] <= clamp_x(req_x2[i*X_WIDTH +: X_WIDTH]);
        r_slot_y2[i] <= clamp_y(req_y2[i*Y_WIDTH +: Y_WIDTH]);
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_req_ready <= '1;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_start     <= 1'b0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_x2        <= '0;
      r_y2        <= '0;
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (w_accept[i]) begin
          r_pending[i]   <= 1'b1;
          r_req_ready[i] <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_x1    <= r_slot_x1[w_winner];
            r_y1    <= r_slot_y1[w_winner];
            r_x2    <= r_slot_x2[w_winner];
            r_y2    <= r_slot_y2[w_winner];
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        // The drawer gets this cycle to drop ready, so ready is not sampled here.
        S_ISSUE: begin
          r_start <= 1'b0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (line_drawer_ready) begin
            r_pending[r_grant]   <= 1'b0;
            r_req_ready[r_grant] <= 1'b1;
            r_rr_ptr             <= w_next_ptr;
            r_state              <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready         = r_req_ready;
  assign x1                = r_x1;
  assign y1                = r_y1;
  assign x2                = r_x2;
  assign y2                = r_y2;
  assign line_drawer_start = r_start;
  assign busy              = (r_state != S_IDLE);
  assign grant             = r_grant;

endmodule

// File: tb/tb_line_drawer_arbiter.sv
// Bench for line_drawer_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_line_drawer_arbiter;

  localparam int N  = 3;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_start;
  logic [N-1:0]    req_ready;
  logic [N*XW-1:0] req_x1, req_x2;
  logic [N*YW-1:0] req_y1, req_y2;
  logic [XW-1:0]   x1, x2;
  logic [YW-1:0]   y1, y2;
  logic            ld_start;
  logic            ld_ready;
  logic            busy;
  logic [GW-1:0]   grant;

  int n_pass  = 0;
  int n_total = 0;

  // Drawer emulation and start-pulse log
  int  draw_len    = 0;
  int  draw_cnt    = 0;
  bit  rand_drawer = 0;
  int  got_grant [$];
  logic [37:0] got_coords [$];

  // Reference model state
  bit  model_on = 0;
  bit  m_pending [N];
  int  m_sx1 [N], m_sy1 [N], m_sx2 [N], m_sy2 [N];
  int  m_ptr, m_phase, m_grant;
  int  m_x1, m_y1, m_x2, m_y2;
  bit  m_start;

  line_drawer_arbiter #(
    .HOR_ACTIVE_PIXELS(640),
    .VER_ACTIVE_PIXELS(480),
    .REQUESTERS(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_start(req_start),
    .req_ready(req_ready),
    .req_x1(req_x1),
    .req_y1(req_y1),
    .req_x2(req_x2),
    .req_y2(req_y2),
    .x1(x1),
    .y1(y1),
    .x2(x2),
    .y2(y2),
    .line_drawer_start(ld_start),
    .line_drawer_ready(ld_ready),
    .busy(busy),
    .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic int clip(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pending[i] = 0;
      m_sx1[i] = 0; m_sy1[i] = 0; m_sx2[i] = 0; m_sy2[i] = 0;
    end
    m_ptr = 0; m_phase = 0; m_grant = 0; m_start = 0;
    m_x1 = 0; m_y1 = 0; m_x2 = 0; m_y2 = 0;
  endtask

  // Phase 0: free; 1: start pulse just issued; 2: waiting for the drawer.
  task automatic model_edge();
    bit old_p [N];
    bit found;
    int idx;
    for (int i = 0; i < N; i++) old_p[i] = m_pending[i];
    found = 0;
    case (m_phase)
      0: begin
        m_start = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && old_p[idx]) begin
            found   = 1;
            m_grant = idx;
            m_x1 = m_sx1[idx]; m_y1 = m_sy1[idx];
            m_x2 = m_sx2[idx]; m_y2 = m_sy2[idx];
            m_start = 1;
            m_phase = 1;
          end
        end
      end
      1: begin
        m_start = 0;
        m_phase = 2;
      end
      default: begin
        if (ld_ready) begin
          m_pending[m_grant] = 0;
          m_ptr   = (m_grant + 1) % N;
          m_phase = 0;
        end
      end
    endcase
    for (int i = 0; i < N; i++) begin
      if (req_start[i] && !old_p[i]) begin
        m_pending[i] = 1;
        m_sx1[i] = clip(int'(req_x1[i*XW +: XW]), 640);
        m_sy1[i] = clip(int'(req_y1[i*YW +: YW]), 480);
        m_sx2[i] = clip(int'(req_x2[i*XW +: XW]), 640);
        m_sy2[i] = clip(int'(req_y2[i*YW +: YW]), 480);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_edge();
    @(negedge clk);
    if (ld_start) begin
      got_grant.push_back(int'(grant));
      got_coords.push_back({x1, y1, x2, y2});
    end
    if (draw_cnt > 0) begin
      draw_cnt--;
      if (draw_cnt == 0) ld_ready = 1'b1;
    end
    if (ld_start) begin
      if (rand_drawer) draw_len = $urandom_range(0, 6);
      if (draw_len > 0) begin
        ld_ready = 1'b0;
        draw_cnt = draw_len;
      end
    end
  endtask

  task automatic set_line(input int i, input int ax1, input int ay1, input int ax2, input int ay2);
    req_x1[i*XW +: XW] = XW'(ax1);
    req_y1[i*YW +: YW] = YW'(ay1);
    req_x2[i*XW +: XW] = XW'(ax2);
    req_y2[i*YW +: YW] = YW'(ay2);
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    req_start = mask;
    tick();
    req_start = '0;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) tick();
  endtask

  task automatic clear_log();
    got_grant.delete();
    got_coords.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_start = '0; ld_ready = 1'b1; draw_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_start = '0; ld_ready = 1'b1;
    req_x1 = '0; req_y1 = '0; req_x2 = '0; req_y2 = '0;
    @(negedge clk);
    n_total++;
    if (req_ready !== 3'b111) $display("FAIL reset_req_ready: got %b expected 111", req_ready);
    else n_pass++;
    n_total++;
    if (ld_start !== 1'b0 || busy !== 1'b0 || grant !== 2'd0)
      $display("FAIL reset_ctrl: got start=%b busy=%b grant=%0d expected 0 0 0", ld_start, busy, grant);
    else n_pass++;
    n_total++;
    if ({x1, y1, x2, y2} !== 38'd0)
      $display("FAIL reset_coords: got %0d %0d %0d %0d expected all 0", x1, y1, x2, y2);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0 || ld_start !== 1'b0 || req_ready !== 3'b111)
      $display("FAIL reset_release_idle: got busy=%b start=%b ready=%b expected 0 0 111", busy, ld_start, req_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    draw_len = 0; ld_ready = 1'b1;
    set_line(0, 10, 20, 100, 200);
    pulse(3'b001);
    n_total++;
    if (req_ready !== 3'b110 || ld_start !== 1'b0)
      $display("FAIL single_accept: got ready=%b start=%b expected 110 0", req_ready, ld_start);
    else n_pass++;
    tick();
    n_total++;
    if (ld_start !== 1'b1 || busy !== 1'b1 || grant !== 2'd0)
      $display("FAIL single_start: got start=%b busy=%b grant=%0d expected 1 1 0", ld_start, busy, grant);
    else n_pass++;
    n_total++;
    if (x1 !== 10'd10 || y1 !== 9'd20 || x2 !== 10'd100 || y2 !== 9'd200)
      $display("FAIL single_coords: got %0d,%0d,%0d,%0d expected 10,20,100,200", x1, y1, x2, y2);
    else n_pass++;
    tick();
    n_total++;
    if (ld_start !== 1'b0 || req_ready[0] !== 1'b0)
      $display("FAIL single_one_pulse: got start=%b ready0=%b expected 0 0", ld_start, req_ready[0]);
    else n_pass++;
    tick();
    n_total++;
    if (req_ready !== 3'b111 || busy !== 1'b0)
      $display("FAIL single_done: got ready=%b busy=%b expected 111 0", req_ready, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [37:0] exp_c;
    do_reset();
    draw_len = 5;
    for (int i = 0; i < N; i++) set_line(i, 100 + i, 50 + i, 200 + i, 150 + i);
    clear_log();
    pulse(3'b111);
    run(45);
    n_total++;
    if (got_grant.size() != 3) $display("FAIL rr_count: got %0d starts expected 3", got_grant.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      if (k < got_grant.size()) begin
        exp_c = {10'(100 + k), 9'(50 + k), 10'(200 + k), 9'(150 + k)};
        n_total++;
        if (got_grant[k] != k || got_coords[k] !== exp_c)
          $display("FAIL rr_order_%0d: got grant %0d coords %h expected grant %0d coords %h",
                   k, got_grant[k], got_coords[k], k, exp_c);
        else n_pass++;
      end
    end
    pulse(3'b001);
    run(20);
    clear_log();
    pulse(3'b101);
    run(40);
    n_total++;
    if (got_grant.size() != 2 || got_grant[0] != 2 || got_grant[1] != 0)
      $display("FAIL rr_ptr1_order: got %0d starts first=%0d expected 2 starts order 2,0",
               got_grant.size(), (got_grant.size() > 0) ? got_grant[0] : -1);
    else n_pass++;
  endtask

  task automatic test_clamp();
    draw_len = 0; ld_ready = 1'b1;
    set_line(1, 700, 500, 639, 479);
    clear_log();
    pulse(3'b010);
    run(15);
    n_total++;
    if (got_grant.size() != 1 || got_grant[0] != 1 || got_coords[0] !== {10'd639, 9'd479, 10'd639, 9'd479})
      $display("FAIL clamp: got %0d starts coords %h expected 1 start coords %h", got_grant.size(),
               (got_coords.size() > 0) ? got_coords[0] : 38'd0, {10'd639, 9'd479, 10'd639, 9'd479});
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    draw_len = 5;
    clear_log();
    set_line(0, 1, 2, 3, 4);
    pulse(3'b001);
    set_line(0, 5, 6, 7, 8);
    pulse(3'b001);
    tick();
    pulse(3'b001);
    run(30);
    n_total++;
    if (got_grant.size() != 1 || got_grant[0] != 0 || got_coords[0] !== {10'd1, 9'd2, 10'd3, 9'd4})
      $display("FAIL busy_ignore: got %0d starts coords %h expected 1 start coords %h", got_grant.size(),
               (got_coords.size() > 0) ? got_coords[0] : 38'd0, {10'd1, 9'd2, 10'd3, 9'd4});
    else n_pass++;
  endtask

  task automatic test_stall();
    int bad;
    draw_len = 0; ld_ready = 1'b1;
    clear_log();
    set_line(2, 30, 40, 50, 60);
    pulse(3'b100);
    tick();
    ld_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (busy !== 1'b1 || ld_start !== 1'b0 || req_ready[2] !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_total++;
    if (got_grant.size() != 1) $display("FAIL stall_single_start: got %0d starts expected 1", got_grant.size());
    else n_pass++;
    ld_ready = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0 || req_ready !== 3'b111)
      $display("FAIL stall_release: got busy=%b ready=%b expected 0 111", busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    draw_len = 0; ld_ready = 1'b1;
    set_line(0, 11, 12, 13, 14);
    pulse(3'b001);
    run(5);
    ld_ready = 1'b0;
    set_line(1, 21, 22, 23, 24);
    set_line(2, 31, 32, 33, 34);
    pulse(3'b110);
    run(4);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (ld_start !== 1'b0 || busy !== 1'b0 || req_ready !== 3'b111)
      $display("FAIL async_reset: got start=%b busy=%b ready=%b expected 0 0 111", ld_start, busy, req_ready);
    else n_pass++;
    n_total++;
    if (grant !== 2'd0 || {x1, y1, x2, y2} !== 38'd0)
      $display("FAIL async_reset_regs: got grant=%0d coords %h expected 0 0", grant, {x1, y1, x2, y2});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ld_ready = 1'b1;
    clear_log();
    pulse(3'b011);
    run(20);
    n_total++;
    if (got_grant.size() != 2 || got_grant[0] != 0 || got_grant[1] != 1)
      $display("FAIL async_reset_after: got %0d starts first=%0d expected 2 starts order 0,1",
               got_grant.size(), (got_grant.size() > 0) ? got_grant[0] : -1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ready;
    do_reset();
    rand_drawer = 1;
    model_on = 1;
    for (int c = 0; c < 800; c++) begin
      req_start = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 7)) : '0;
      req_x1 = 30'($urandom); req_x2 = 30'($urandom);
      req_y1 = 27'($urandom); req_y2 = 27'($urandom);
      tick();
      for (int i = 0; i < N; i++) exp_ready[i] = !m_pending[i];
      n_total++;
      if (req_ready !== exp_ready) $display("FAIL rand_ready @%0d: got %b expected %b", c, req_ready, exp_ready);
      else n_pass++;
      n_total++;
      if (busy !== (m_phase != 0)) $display("FAIL rand_busy @%0d: got %b expected %b", c, busy, m_phase != 0);
      else n_pass++;
      n_total++;
      if (ld_start !== m_start) $display("FAIL rand_start @%0d: got %b expected %b", c, ld_start, m_start);
      else n_pass++;
      n_total++;
      if ({x1, y1, x2, y2} !== {10'(m_x1), 9'(m_y1), 10'(m_x2), 9'(m_y2)})
        $display("FAIL rand_coords @%0d: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                 c, x1, y1, x2, y2, m_x1, m_y1, m_x2, m_y2);
      else n_pass++;
      if (m_phase != 0) begin
        n_total++;
        if (grant !== GW'(m_grant)) $display("FAIL rand_grant @%0d: got %0d expected %0d", c, grant, m_grant);
        else n_pass++;
      end
    end
    req_start = '0;
    model_on = 0;
    rand_drawer = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_busy_ignore();
    test_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/line_drawer_arbiter.md
Name: line_drawer_arbiter

Overview:
Shares the single line_drawer between REQUESTERS independent line sources, such as the function-plot sequencer, an axis/grid drawer and a cursor overlay. Each requester hands over one line through a start/ready handshake. The block buffers one pending line per requester, grants the drawer round-robin, and drives the drawer's x1/y1/x2/y2/start/ready handshake. It sits between the requesters and the line_drawer instance in the top-level design.

Parameters:
HOR_ACTIVE_PIXELS, 640, screen width; X_WIDTH = $clog2(HOR_ACTIVE_PIXELS) (local).
VER_ACTIVE_PIXELS, 480, screen height; Y_WIDTH = $clog2(VER_ACTIVE_PIXELS) (local).
REQUESTERS, 3, number of line sources (>=2); GRANT_WIDTH = $clog2(REQUESTERS) (local).

Ports:
clk  input  1  clock; every flop is rising-edge.
rst_n  input  1  asynchronous active-low reset.
req_start  input  REQUESTERS  per-requester one-cycle start pulse.
req_ready  output  REQUESTERS  per-requester "slot free".
req_x1  input  REQUESTERS*X_WIDTH  flattened; slice i is [i*X_WIDTH +: X_WIDTH].
req_y1  input  REQUESTERS*Y_WIDTH  flattened, same slicing.
req_x2  input  REQUESTERS*X_WIDTH  flattened.
req_y2  input  REQUESTERS*Y_WIDTH  flattened.
x1  output  X_WIDTH  registered line start x to line_drawer.
y1  output  Y_WIDTH  registered line start y.
x2  output  X_WIDTH  registered line end x.
y2  output  Y_WIDTH  registered line end y.
line_drawer_start  output  1  one-cycle start pulse to line_drawer.
line_drawer_ready  input  1  line_drawer idle/done.
busy  output  1  high when state != IDLE.
grant  output  GRANT_WIDTH  index of the requester being served (valid while busy).

Behaviour:
- Reset: one clock; asynchronous, active-low. While rst_n=0, all of the following hold immediately:
  - req_ready all 1, pending all 0;
  - x1=y1=x2=y2=0, line_drawer_start=0;
  - busy=0, grant=0, rr_ptr=0, state=IDLE.
- Acceptance:
  - A line from requester i is accepted at an edge where req_start[i]=1 and req_ready[i]=1.
  - The four coordinate slices are captured into slot i, pending[i] is set, and req_ready[i] drops.
  - req_start[i] while req_ready[i]=0 is ignored; no error is flagged.
- Clamping at capture: any x >= HOR_ACTIVE_PIXELS is stored as HOR_ACTIVE_PIXELS-1, and any y >= VER_ACTIVE_PIXELS is stored as VER_ACTIVE_PIXELS-1.
- Arbitration: round-robin. Search pending starting at rr_ptr, ascending, wrapping at REQUESTERS-1 back to 0. The first pending index found wins.
- FSM (registered, 3 states):
  - IDLE: if any pending, then grant<=winner; x1/y1/x2/y2<=slot[winner]; line_drawer_start<=1; go to ISSUE.
  - ISSUE: line_drawer_start<=0; go to WAIT_DONE. line_drawer_ready is not sampled here, because the drawer is allowed one cycle to drop ready.
  - WAIT_DONE: when line_drawer_ready=1, then pending[grant]<=0; req_ready[grant]<=1; rr_ptr<=(grant+1) wrapped modulo REQUESTERS; go to IDLE.
- Latency: acceptance at edge E0 -> line_drawer_start high for the cycle after E1 (exactly one cycle) -> req_ready[i] returns at the edge where WAIT_DONE sees ready. Minimum of 3 clocks per line, plus drawer time.
- Simultaneous events:
  - Acceptance of requester i in the same cycle IDLE evaluates pending: i is not eligible until the next cycle (pending is registered).
  - Completion of requester g and req_start[g] in the same cycle: start is ignored, because req_ready[g] is still 0 that cycle.
  - Acceptance of requester j != grant during ISSUE or WAIT_DONE proceeds normally.
- Registered outputs: x1/y1/x2/y2 are stable from the start pulse until the next grant, and change only in IDLE.
- Reset mid-operation: pending lines are discarded and line_drawer_start is forced low asynchronously. The line_drawer shares rst_n, so a partially drawn line is abandoned.
- No starvation: with all requesters continuously pending, each is served once per REQUESTERS grants.

Test Plan:
- Single request: reset, then req 0 pulses (10,20)->(100,200) with drawer ready=1. Required: x1=10,y1=20,x2=100,y2=200 with line_drawer_start high one cycle after acceptance; req_ready[0] back to 1 three clocks after acceptance.
- Round-robin: requesters 0, 1 and 2 all start in the same cycle; drawer takes 5 cycles per line. Required: grants in order 0,1,2. Next, with rr_ptr=1, requesters 0 and 2 are pending. Required: grant order 2, then 0.
- Clamp: req 1 sends (700,500)->(639,479). Required: x1=639, y1=479, x2=639, y2=479.
- Busy ignore: req 0 pulses start again while its line is pending. Required: second coordinates are ignored, and only one line_drawer_start is issued for req 0.
- Drawer stall: line_drawer_ready is held 0 for 50 cycles after the start pulse. Required: FSM stays in WAIT_DONE, busy=1, no second start pulse; completion follows exactly one edge after ready returns.
- Async reset mid-line: assert rst_n=0 during WAIT_DONE between clock edges. Required: line_drawer_start=0, busy=0, req_ready all 1 without a clock edge; after release, a fresh request is served normally starting with requester 0 priority.
